// File: rtl/vcve2_pkg.sv
//------------------------------------------------------------------------------
// vcve2_pkg
// Shared types for the vector register file sequencer: FSM states and LMUL.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vcve2_pkg;

    typedef enum logic [2:0] {
        VRF_IDLE    = 3'd0,
        VRF_START   = 3'd1,
        VRF_READ    = 3'd2,
        VRF_WAITBUS = 3'd3,
        VRF_EXEC    = 3'd4,
        VRF_WRITE   = 3'd5
    } vrf_seq_state_t;

    typedef enum logic [2:0] {
        VLMUL_1    = 3'b000,
        VLMUL_2    = 3'b001,
        VLMUL_4    = 3'b010,
        VLMUL_8    = 3'b011,
        VLMUL_RSVD = 3'b100,
        VLMUL_F8   = 3'b101,
        VLMUL_F4   = 3'b110,
        VLMUL_F2   = 3'b111
    } vlmul_e;

    // log2 of the register group size; fractional and reserved encodings use one register
    function automatic logic [1:0] vlmul_to_shift(input vlmul_e lmul);
        case (lmul)
            VLMUL_2: vlmul_to_shift = 2'd1;
            VLMUL_4: vlmul_to_shift = 2'd2;
            VLMUL_8: vlmul_to_shift = 2'd3;
            default: vlmul_to_shift = 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/vcve2_vrf_addr_gen.sv
//------------------------------------------------------------------------------
// vcve2_vrf_addr_gen
// Maps a base vreg and a group-wide word counter to the bus word address.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vcve2_vrf_addr_gen #(
    parameter int  WPR = 4,
    localparam int WIDX_W = $clog2(WPR),
    localparam int CNT_W = WIDX_W + 3,
    localparam int AW = 5 + WIDX_W
) (
    input  logic [4:0]       vreg,
    input  logic [CNT_W-1:0] word,
    output logic [AW-1:0]    addr
);

    generate
        if (WIDX_W == 0) begin : g_one_word
            assign addr = vreg + 5'(word);
        end else begin : g_multi_word
            assign addr = {vreg + 5'(word >> WIDX_W), word[WIDX_W-1:0]};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vcve2_vrf_seq.sv
//------------------------------------------------------------------------------
// vcve2_vrf_seq
// Sequences VRF operand reads, datapath handshake and result write-back per
// word. Define VCVE2_VRF_LMUL_EN to enable register grouping and alignment check.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vcve2_vrf_seq
    import vcve2_pkg::*;
#(
    parameter int  VLEN = 128,
    parameter int  BUS_W = 32,
    parameter int  NUM_RD = 3,
    localparam int WPR = VLEN / BUS_W,
    localparam int WIDX_W = $clog2(WPR),
    localparam int AW = 5 + WIDX_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    output logic                    ready_o,
    input  logic                    kill_i,
    input  logic [1:0]              num_src_i,
    input  logic [NUM_RD*5-1:0]     vs_addr_i,
    input  logic [4:0]              vd_addr_i,
    input  logic                    vd_we_i,
    input  logic [2:0]              vlmul_i,
    output logic                    bus_req_o,
    input  logic                    bus_gnt_i,
    output logic                    bus_we_o,
    output logic [AW-1:0]           bus_addr_o,
    output logic [BUS_W-1:0]        bus_wdata_o,
    input  logic                    bus_rvalid_i,
    input  logic [BUS_W-1:0]        bus_rdata_i,
    output logic                    op_valid_o,
    output logic [NUM_RD*BUS_W-1:0] op_data_o,
    input  logic                    res_valid_i,
    input  logic [BUS_W-1:0]        res_data_i,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int CNT_W = WIDX_W + 3;

    vrf_seq_state_t state, state_nxt;

    logic [NUM_RD*5-1:0]     vs_q;
    logic [4:0]              vd_q;
    logic                    vd_we_q;
    logic [1:0]              nsrc_q;
    logic [1:0]              gsh_q;
    logic [CNT_W-1:0]        word_q;
    logic [1:0]              src_q;
    logic [NUM_RD*BUS_W-1:0] opd_q;
    logic [BUS_W-1:0]        res_q;

    logic             latch;
    logic             cap;
    logic             src_inc;
    logic             adv;
    logic             res_cap;
    logic             misalign;
    logic [CNT_W-1:0] words_m1;
    logic [4:0]       cur_vreg;
    logic [AW-1:0]    gen_addr;

    assign latch    = (state == VRF_IDLE) && start_i && !kill_i;
    assign res_cap  = (state == VRF_EXEC) && res_valid_i && !kill_i;
    assign words_m1 = CNT_W'((WPR << gsh_q) - 1);

`ifdef VCVE2_VRF_LMUL_EN
    logic [4:0] gmask;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gsh_q <= 2'd0;
        end else if (latch) begin
            gsh_q <= vlmul_to_shift(vlmul_e'(vlmul_i));
        end
    end

    always_comb begin
        gmask    = 5'((1 << gsh_q) - 1);
        misalign = vd_we_q && ((vd_q & gmask) != 5'd0);
        for (int i = 0; i < NUM_RD; i++) begin
            if ((int'(nsrc_q) > i) && ((vs_q[i*5 +: 5] & gmask) != 5'd0)) begin
                misalign = 1'b1;
            end
        end
    end
`else
    logic unused_vlmul;

    assign unused_vlmul = ^vlmul_i;
    assign gsh_q        = 2'd0;
    assign misalign     = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= VRF_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_o    = 1'b0;
        err_o     = 1'b0;
        adv       = 1'b0;
        cap       = 1'b0;
        src_inc   = 1'b0;
        case (state)
            VRF_IDLE: begin
                if (start_i) state_nxt = VRF_START;
            end
            VRF_START: begin
                if (misalign) begin
                    err_o     = 1'b1;
                    state_nxt = VRF_IDLE;
                end else if (nsrc_q == 2'd0) begin
                    state_nxt = VRF_EXEC;
                end else begin
                    state_nxt = VRF_READ;
                end
            end
            VRF_READ: begin
                if (bus_gnt_i) state_nxt = VRF_WAITBUS;
            end
            VRF_WAITBUS: begin
                if (bus_rvalid_i) begin
                    cap = 1'b1;
                    if (({1'b0, src_q} + 3'd1) < {1'b0, nsrc_q}) begin
                        src_inc   = 1'b1;
                        state_nxt = VRF_READ;
                    end else begin
                        state_nxt = VRF_EXEC;
                    end
                end
            end
            VRF_EXEC: begin
                if (res_valid_i) begin
                    if (vd_we_q) state_nxt = VRF_WRITE;
                    else         adv       = 1'b1;
                end
            end
            VRF_WRITE: begin
                if (bus_gnt_i) adv = 1'b1;
            end
            default: state_nxt = VRF_IDLE;
        endcase

        if (adv) begin
            if (word_q == words_m1) begin
                done_o    = 1'b1;
                state_nxt = VRF_IDLE;
            end else begin
                state_nxt = (nsrc_q == 2'd0) ? VRF_EXEC : VRF_READ;
            end
        end

        // abort wins over every completion, capture and error event
        if (kill_i) begin
            state_nxt = VRF_IDLE;
            done_o    = 1'b0;
            err_o     = 1'b0;
            adv       = 1'b0;
            cap       = 1'b0;
            src_inc   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_q    <= '0;
            vd_q    <= 5'd0;
            vd_we_q <= 1'b0;
            nsrc_q  <= 2'd0;
            word_q  <= '0;
            src_q   <= 2'd0;
            opd_q   <= '0;
            res_q   <= '0;
        end else begin
            if (latch) begin
                vs_q    <= vs_addr_i;
                vd_q    <= vd_addr_i;
                vd_we_q <= vd_we_i;
                nsrc_q  <= (int'(num_src_i) > NUM_RD) ? 2'(NUM_RD) : num_src_i;
                word_q  <= '0;
                src_q   <= 2'd0;
                opd_q   <= '0;
            end
            if (cap) opd_q[int'(src_q)*BUS_W +: BUS_W] <= bus_rdata_i;
            if (src_inc) src_q <= src_q + 2'd1;
            if (adv) begin
                word_q <= word_q + 1'b1;
                src_q  <= 2'd0;
            end
            if (res_cap) res_q <= res_data_i;
        end
    end

    assign cur_vreg = (state == VRF_WRITE) ? vd_q : vs_q[int'(src_q)*5 +: 5];

    vcve2_vrf_addr_gen #(
        .WPR (WPR)
    ) u_addr_gen (
        .vreg (cur_vreg),
        .word (word_q),
        .addr (gen_addr)
    );

    assign ready_o     = (state == VRF_IDLE);
    assign bus_req_o   = (state == VRF_READ) || (state == VRF_WRITE);
    assign bus_we_o    = (state == VRF_WRITE);
    assign bus_addr_o  = bus_req_o ? gen_addr : '0;
    assign bus_wdata_o = (state == VRF_WRITE) ? res_q : '0;
    assign op_valid_o  = (state == VRF_EXEC);
    assign op_data_o   = (state == VRF_EXEC) ? opd_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_vcve2_vrf_seq.sv
//------------------------------------------------------------------------------
// tb_vcve2_vrf_seq
// Directed bench: bus memory model, adder datapath, per-step assertions.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vcve2_vrf_seq;
    import vcve2_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        ready_o;
    logic        kill_i = 1'b0;
    logic [1:0]  num_src_i = 2'd0;
    logic [14:0] vs_addr_i = '0;
    logic [4:0]  vd_addr_i = '0;
    logic        vd_we_i = 1'b0;
    logic [2:0]  vlmul_i = 3'd0;
    logic        bus_req_o;
    logic        bus_gnt_i;
    logic        bus_we_o;
    logic [6:0]  bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        op_valid_o;
    logic [95:0] op_data_o;
    logic        res_valid_i;
    logic [31:0] res_data_i;
    logic        done_o;
    logic        err_o;

    logic        gnt_en = 1'b1;
    int          rv_delay = 0;

    always #5 clk = ~clk;

    vcve2_vrf_seq u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start_i),
        .ready_o      (ready_o),
        .kill_i       (kill_i),
        .num_src_i    (num_src_i),
        .vs_addr_i    (vs_addr_i),
        .vd_addr_i    (vd_addr_i),
        .vd_we_i      (vd_we_i),
        .vlmul_i      (vlmul_i),
        .bus_req_o    (bus_req_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_rvalid_i (rvalid),
        .bus_rdata_i  (rdata),
        .op_valid_o   (op_valid_o),
        .op_data_o    (op_data_o),
        .res_valid_i  (res_valid_i),
        .res_data_i   (res_data_i),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    // adder datapath answering in the same cycle as the operands
    assign bus_gnt_i   = bus_req_o & gnt_en;
    assign res_valid_i = op_valid_o;
    assign res_data_i  = op_data_o[31:0] + op_data_o[63:32] + op_data_o[95:64];

    function automatic logic [31:0] init_val(input int a);
        return 32'h5A5A_0001 + 32'(a) * 32'h0103_0507;
    endfunction

    logic [31:0] mem [0:127];
    logic [7:0]  log_e [0:255];
    int          log_n = 0;
    logic [31:0] pend_data = '0;
    int pend_cnt = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    int done_wr = 0, req_cyc = 0, opv_cyc = 0, op_nz = 0;
    int start_cyc = 0, done_cyc = 0, err_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
            rvalid   <= 1'b0;
            pend_cnt <= 0;
        end else begin
            rvalid <= 1'b0;
            if (pend_cnt == 1) begin
                rvalid <= 1'b1;
                rdata  <= pend_data;
            end
            if (pend_cnt != 0) pend_cnt <= pend_cnt - 1;
            if (bus_req_o && bus_gnt_i) begin
                if (log_n < 256) log_e[log_n] <= {bus_we_o, bus_addr_o};
                log_n <= log_n + 1;
                if (bus_we_o) begin
                    mem[bus_addr_o] <= bus_wdata_o;
                    wr_cnt <= wr_cnt + 1;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                    if (rv_delay == 0) begin
                        rvalid <= 1'b1;
                        rdata  <= mem[bus_addr_o];
                    end else begin
                        pend_cnt  <= rv_delay;
                        pend_data <= mem[bus_addr_o];
                    end
                end
            end
            if (bus_req_o) req_cyc <= req_cyc + 1;
            if (done_o) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
                if (bus_we_o && bus_gnt_i) done_wr <= done_wr + 1;
            end
            if (err_o) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
            if (start_i && ready_o) start_cyc <= cyc;
            if (op_valid_o) begin
                opv_cyc <= opv_cyc + 1;
                if (op_data_o != '0) op_nz <= op_nz + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] ns, input logic [14:0] vs, input logic [4:0] vd,
                          input logic we, input logic [2:0] lm);
        @(negedge clk);
        num_src_i = ns;
        vs_addr_i = vs;
        vd_addr_i = vd;
        vd_we_i   = we;
        vlmul_i   = lm;
        start_i   = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!ready_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ready_o), 32'd1);
    endtask

    task automatic wait_req(input int budget, input string tag);
        int n = 0;
        while (!bus_req_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus_req_o), 32'd1);
    endtask

`ifdef VCVE2_VRF_LMUL_EN
    localparam int NW4 = 16;
`else
    localparam int NW4 = 4;
`endif

    int rd0, wr0, dn0, er0, dw0, rq0, ov0, nz0, lg0;

    task automatic snap();
        rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
        dw0 = done_wr; rq0 = req_cyc; ov0 = opv_cyc; nz0 = op_nz; lg0 = log_n;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_req", 32'({bus_req_o, bus_we_o, op_valid_o, done_o, err_o}), 32'd0);
        check("rst_addr", 32'(bus_addr_o), 32'd0);
        check("rst_wdata", bus_wdata_o, 32'd0);
        check("rst_opdata", 32'(|op_data_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // v3 = v1 + v2 over one register
        snap();
        run_op(2'd2, {5'd0, 5'd2, 5'd1}, 5'd3, 1'b1, VLMUL_1);
        wait_idle(100, "add_idle");
        check("add_reads", rd_cnt - rd0, 32'd8);
        check("add_writes", wr_cnt - wr0, 32'd4);
        check("add_done", done_cnt - dn0, 32'd1);
        check("add_done_on_wr", done_wr - dw0, 32'd1);
        check("add_latency", done_cyc - start_cyc, 32'd25);
        check("add_err", err_cnt - er0, 32'd0);
        for (int k = 0; k < 4; k++)
            check($sformatf("add_v3w%0d", k), mem[12+k], init_val(4+k) + init_val(8+k));

        // vs=v3 with LMUL_2
        snap();
        run_op(2'd1, {5'd0, 5'd0, 5'd3}, 5'd0, 1'b0, VLMUL_2);
        wait_idle(100, "mis_idle");
`ifdef VCVE2_VRF_LMUL_EN
        check("mis_err", err_cnt - er0, 32'd1);
        check("mis_err_lat", err_cyc - start_cyc, 32'd1);
        check("mis_noreq", req_cyc - rq0, 32'd0);
        check("mis_nodone", done_cnt - dn0, 32'd0);
        // misaligned index in an unused slot must be ignored
        snap();
        run_op(2'd1, {5'd0, 5'd3, 5'd2}, 5'd0, 1'b0, VLMUL_2);
        wait_idle(100, "unused_idle");
        check("unused_err", err_cnt - er0, 32'd0);
        check("unused_reads", rd_cnt - rd0, 32'd8);
        check("unused_done", done_cnt - dn0, 32'd1);
        // misaligned destination
        snap();
        run_op(2'd0, 15'd0, 5'd5, 1'b1, VLMUL_2);
        wait_idle(100, "vdmis_idle");
        check("vdmis_err", err_cnt - er0, 32'd1);
        check("vdmis_nowr", wr_cnt - wr0, 32'd0);
`else
        check("nolmul_err", err_cnt - er0, 32'd0);
        check("nolmul_reads", rd_cnt - rd0, 32'd4);
        check("nolmul_done", done_cnt - dn0, 32'd1);
`endif

        // copy v4 group to v8 group with LMUL_4
        snap();
        run_op(2'd1, {5'd0, 5'd0, 5'd4}, 5'd8, 1'b1, VLMUL_4);
        wait_idle(400, "grp_idle");
        check("grp_writes", wr_cnt - wr0, NW4);
        check("grp_done", done_cnt - dn0, 32'd1);
        for (int k = 0; k < NW4; k++) begin
            check($sformatf("grp_rd%0d", k), 32'(log_e[lg0+2*k]), 32'(16 + k));
            check($sformatf("grp_wr%0d", k), 32'(log_e[lg0+2*k+1]), 32'(128 + 32 + k));
        end
        check("grp_mem_first", mem[32], init_val(16));
        check("grp_mem_last", mem[32+NW4-1], init_val(16+NW4-1));

        // grant withheld: request must hold still; a second start is ignored
        snap();
        gnt_en = 1'b0;
        run_op(2'd2, {5'd0, 5'd13, 5'd12}, 5'd14, 1'b1, VLMUL_1);
        wait_req(5, "hold_req");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_addr%0d", i), 32'(bus_addr_o), 32'd48);
            check($sformatf("hold_we%0d", i), 32'({bus_req_o, bus_we_o}), 32'd2);
            if (i == 1) begin
                num_src_i = 2'd0;
                vd_addr_i = 5'd20;
                start_i   = 1'b1;
            end
            if (i == 2) start_i = 1'b0;
            @(negedge clk);
        end
        gnt_en = 1'b1;
        wait_idle(100, "hold_idle");
        check("hold_reads", rd_cnt - rd0, 32'd8);
        check("hold_writes", wr_cnt - wr0, 32'd4);
        check("hold_done", done_cnt - dn0, 32'd1);
        check("hold_v14w0", mem[56], init_val(48) + init_val(52));
        check("hold_v14w3", mem[59], init_val(51) + init_val(55));

        // three sources, no write-back
        snap();
        run_op(2'd3, {5'd6, 5'd5, 5'd4}, 5'd0, 1'b0, VLMUL_1);
        wait_idle(100, "three_idle");
        check("three_reads", rd_cnt - rd0, 32'd12);
        check("three_writes", wr_cnt - wr0, 32'd0);
        check("three_latency", done_cyc - start_cyc, 32'd29);

        // kill while waiting for read data; late rvalid arrives afterwards
        snap();
        rv_delay = 3;
        run_op(2'd2, {5'd0, 5'd17, 5'd16}, 5'd18, 1'b1, VLMUL_1);
        wait_req(5, "kill_req");
        @(negedge clk);
        check("kill_waitbus_noreq", 32'(bus_req_o), 32'd0);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        check("kill_ready", 32'(ready_o), 32'd1);
        repeat (6) @(negedge clk);
        check("kill_still_idle", 32'({ready_o, bus_req_o, op_valid_o}), 32'd4);
        check("kill_reads", rd_cnt - rd0, 32'd1);
        check("kill_writes", wr_cnt - wr0, 32'd0);
        check("kill_nodone", done_cnt - dn0, 32'd0);
        check("kill_mem", mem[72], init_val(72));
        rv_delay = 0;

        // no sources: writes of zero only
        snap();
        run_op(2'd0, {5'd7, 5'd7, 5'd7}, 5'd20, 1'b1, VLMUL_1);
        wait_idle(100, "zero_idle");
        check("zero_reads", rd_cnt - rd0, 32'd0);
        check("zero_writes", wr_cnt - wr0, 32'd4);
        check("zero_opv", opv_cyc - ov0, 32'd4);
        check("zero_opdata", op_nz - nz0, 32'd0);
        check("zero_latency", done_cyc - start_cyc, 32'd9);
        for (int k = 0; k < 4; k++)
            check($sformatf("zero_v20w%0d", k), mem[80+k], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/vcve2_vrf_seq.md
VCVE2_VRF_SEQ -- requirements
Module: vcve2_vrf_seq

Interface
REQ-001 SHALL have parameter VLEN, default 128, meaning vector register length in bits (power of two, at least BUS_W).
REQ-002 SHALL have parameter BUS_W, default 32, meaning VRF bus data width in bits.
REQ-003 SHALL have parameter NUM_RD, default 3, meaning the maximum number of source vregs per operation (1..3).
REQ-004 SHALL have ports (WPR = VLEN/BUS_W; AW = 5+log2(WPR)); one clock; reset is asynchronous and active-low:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  operation request
- ready_o  out  1  idle, start accepted
- kill_i  in  1  abort current operation
- num_src_i  in  2  source vregs used (0..NUM_RD)
- vs_addr_i  in  NUM_RD*5  source vreg indices, slot 0 in LSBs
- vd_addr_i  in  5  destination vreg index
- vd_we_i  in  1  write result back
- vlmul_i  in  3  vlmul_e grouping
- bus_req_o  out  1  VRF bus request
- bus_gnt_i  in  1  VRF bus grant
- bus_we_o  out  1  write strobe
- bus_addr_o  out  AW  word address {vreg, word}
- bus_wdata_o  out  BUS_W  write data
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  BUS_W  read data
- op_valid_o  out  1  operand bundle valid
- op_data_o  out  NUM_RD*BUS_W  operand words, slot 0 in LSBs
- res_valid_i  in  1  datapath result valid
- res_data_i  in  BUS_W  result word
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle misalignment pulse

Function
REQ-005 SHALL implement states IDLE, START, READ, WAITBUS, EXEC, WRITE.
REQ-006 ready_o SHALL be 1 only in IDLE; start_i outside IDLE SHALL be ignored.
REQ-007 On start_i in IDLE, all inputs SHALL be latched; the FSM SHALL go to START; the word counter and source counter SHALL be cleared.
REQ-008 Group size G SHALL be 1/2/4/8 for VLMUL_1/2/4/8; fractional LMUL SHALL give G=1; total words = G*WPR.
REQ-009 In START, any used vs or vd (if vd_we) index not a multiple of G SHALL pulse err_o and return to IDLE with no bus activity.
REQ-010 In START, num_src_i=0 SHALL go to EXEC; otherwise the FSM SHALL go to READ.
REQ-011 READ SHALL assert bus_req_o (bus_we_o=0) with address {vs[src]+word/WPR, word%WPR} held stable until bus_gnt_i, then go to WAITBUS.
REQ-012 WAITBUS SHALL capture bus_rdata_i into operand slot src on bus_rvalid_i (arriving at least 1 cycle after grant); next: READ (src+1) if more sources remain, else EXEC.
REQ-013 EXEC SHALL hold op_valid_o=1 with unused slots zero until res_valid_i; then WRITE if vd_we, else advance word.
REQ-014 WRITE SHALL assert bus_req_o, bus_we_o=1, address {vd+word/WPR, word%WPR}, bus_wdata_o=captured result; the write SHALL complete on bus_gnt_i.
REQ-015 Word advance: if word = G*WPR-1, pulse done_o and go to IDLE; else word+1, src=0, then READ or EXEC.
REQ-016 At most one bus transaction SHALL be outstanding; bus_req_o SHALL never be asserted in WAITBUS.
REQ-017 kill_i SHALL force IDLE next cycle from any state, with no done_o; a late bus_rvalid_i SHALL be ignored; kill_i SHALL take priority over every other event.
REQ-018 Latency with immediate grant, rvalid 1 cycle after grant, and res_valid in 1 cycle: 2*num_src+1(+1 if write) cycles per word, plus START.

Reset
REQ-019 Reset SHALL set the FSM to IDLE, clear counters and data registers, and drive ready_o=1 with all other outputs 0.

Configuration
REQ-020 With VCVE2_VRF_LMUL_EN defined, grouping and the misalignment check SHALL operate as specified; when undefined, vlmul_i SHALL be ignored, G=1, and err_o SHALL be tied to 0.

Structure
REQ-021 vcve2_pkg SHALL hold vrf_seq_state_t (the six states) and vlmul_e, which is reused.
REQ-022 The address generator (vreg+group offset, word index) SHALL be sub-module vcve2_vrf_addr_gen.

Verification
REQ-023 VLEN=128, BUS_W=32, LMUL_1, 2 sources v1/v2, vd=v3, grant and rvalid immediate: 4 words, 12 bus transactions (8 reads + 4 writes); v3 word k = v1[k]+v2[k] via the bench datapath; done_o after the last write.
REQ-024 LMUL_2 with vs=v3: err_o pulses once within 2 cycles, with no bus_req_o.
REQ-025 LMUL_4, vs=v4, vd=v8: addresses step v4.w0..v7.w3, then v8..v11; 16 done words.
REQ-026 Grant withheld 5 cycles: bus_addr_o/bus_we_o stay stable, with no extra request.
REQ-027 kill_i in WAITBUS, followed by rvalid: IDLE next cycle, ready_o=1, with no write and no done_o.
REQ-028 num_src=0, vd_we=1, LMUL_1: 4 writes only, op_data_o=0.
